// File: rtl/sjf_sched_param.sv
// Shortest-job-first task scheduler with SLOTS slots; executes one time unit per RUN cycle.
// Define SJF_PREEMPT_EN for preemptive shortest-remaining-time-first selection.
module sjf_sched_param #(
    parameter int SLOTS  = 5,
    parameter int RT_W   = 4,
    parameter int ID_W   = 16,
    parameter int TIME_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RT_W-1:0]   in_rt,
    input  logic [ID_W-1:0]   in_id,
    output logic              out_valid,
    output logic [ID_W-1:0]   task_out,
    output logic              done_valid,
    output logic [ID_W-1:0]   done_id,
    output logic [TIME_W-1:0] done_tat,
    output logic              empty,
    output logic              full
);

    localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]        state;
    logic [TIME_W-1:0] timer;
    logic [RT_W-1:0]   rem     [SLOTS];
    logic [TIME_W-1:0] arrival [SLOTS];
    logic [ID_W-1:0]   id_q    [SLOTS];
    logic              lock_vld;
    logic [IDX_W-1:0]  lock_idx;

    logic              run;
    logic [SLOTS-1:0]  occ;
    logic [IDX_W-1:0]  free_idx;
    logic              wr_en;
    logic              sel_vld;
    logic [IDX_W-1:0]  sel_idx;
    logic [RT_W-1:0]   sel_rem;
    logic [TIME_W-1:0] sel_age;
    logic              sel_run;
    logic              exec_vld;
    logic [IDX_W-1:0]  exec_idx;
    logic              exec_last;

    // True when candidate a strictly beats candidate b; equal keys keep the earlier (lower) index.
    function automatic logic better(input logic [RT_W-1:0] rem_a, input logic [TIME_W-1:0] age_a,
                                    input logic run_a, input logic [RT_W-1:0] rem_b,
                                    input logic [TIME_W-1:0] age_b, input logic run_b);
        if (rem_a != rem_b) return rem_a < rem_b;
        if (run_a != run_b) return run_a;
        return age_a > age_b;
    endfunction

    assign run = (state == ST_RUN);

    always_comb begin
        occ      = '0;
        free_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            occ[i] = (rem[i] != '0);
            if (rem[i] == '0) free_idx = IDX_W'(i);
        end
    end

    assign empty    = ~|occ;
    assign full     = &occ;
    assign in_ready = run && !full;
    assign wr_en    = in_valid && in_ready && (in_rt != '0);

    always_comb begin
        logic [TIME_W-1:0] age_i;
        logic              run_i;
        sel_vld = 1'b0;
        sel_idx = '0;
        sel_rem = '0;
        sel_age = '0;
        sel_run = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            age_i = timer - arrival[i];
`ifdef SJF_PREEMPT_EN
            run_i = lock_vld && (lock_idx == IDX_W'(i));
`else
            run_i = 1'b0;
`endif
            if (occ[i] && (!sel_vld || better(rem[i], age_i, run_i, sel_rem, sel_age, sel_run))) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(i);
                sel_rem = rem[i];
                sel_age = age_i;
                sel_run = run_i;
            end
        end
    end

`ifdef SJF_PREEMPT_EN
    // lock only tracks the running slot for tie-breaking; selection is redone every cycle.
    assign exec_vld = run && sel_vld;
    assign exec_idx = sel_idx;
`else
    assign exec_vld = run && (lock_vld || sel_vld);
    assign exec_idx = lock_vld ? lock_idx : sel_idx;
`endif

    assign exec_last  = exec_vld && (rem[exec_idx] == RT_W'(1));
    assign out_valid  = exec_vld;
    assign task_out   = exec_vld ? id_q[exec_idx] : '1;
    assign done_valid = exec_last;
    assign done_id    = exec_last ? id_q[exec_idx] : '0;
    assign done_tat   = exec_last ? (timer - arrival[exec_idx]) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            timer    <= '0;
            lock_vld <= 1'b0;
            lock_idx <= '0;
            for (int i = 0; i < SLOTS; i++) rem[i] <= '0;
        end else begin
            if (state == ST_IDLE && start) state <= ST_RUN;
            if (run) timer <= timer + TIME_W'(1);
            if (exec_vld) begin
                lock_vld <= !exec_last;
                lock_idx <= exec_idx;
            end
            // Accept targets a free slot, execute an occupied one, so they never collide.
            for (int i = 0; i < SLOTS; i++) begin
                if (wr_en && free_idx == IDX_W'(i))
                    rem[i] <= in_rt;
                else if (exec_vld && exec_idx == IDX_W'(i))
                    rem[i] <= rem[i] - RT_W'(1);
            end
        end
    end

    // Payload fields are qualified by rem != 0 and need no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            arrival[free_idx] <= timer;
            id_q[free_idx]    <= in_id;
        end
    end

endmodule

// File: tb/tb_sjf_sched_param.sv
// Self-checking bench for sjf_sched_param: directed scenarios plus randomized traffic
// checked against a key-ordered reference model; follows SJF_PREEMPT_EN when defined.
module tb_sjf_sched_param;

    localparam int SLOTS = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1, start = 1'b0, in_valid = 1'b0;
    logic [3:0]  in_rt = '0;
    logic [15:0] in_id = '0;
    logic        in_ready, out_valid, done_valid, empty, full;
    logic [15:0] task_out, done_id;
    logic [5:0]  done_tat;

    logic        w_rst_n = 1'b1, w_start = 1'b0, w_in_valid = 1'b0;
    logic [3:0]  w_in_rt = '0;
    logic [15:0] w_in_id = '0;
    logic        w_in_ready, w_out_valid, w_done_valid, w_empty, w_full;
    logic [15:0] w_task_out, w_done_id;
    logic [3:0]  w_done_tat;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sjf_sched_param #(.SLOTS(5), .RT_W(4), .ID_W(16), .TIME_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_rt(in_rt), .in_id(in_id), .out_valid(out_valid), .task_out(task_out),
        .done_valid(done_valid), .done_id(done_id), .done_tat(done_tat),
        .empty(empty), .full(full));

    sjf_sched_param #(.SLOTS(5), .RT_W(4), .ID_W(16), .TIME_W(4)) dut_w (
        .clk(clk), .rst_n(w_rst_n), .start(w_start), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_rt(w_in_rt), .in_id(w_in_id), .out_valid(w_out_valid), .task_out(w_task_out),
        .done_valid(w_done_valid), .done_id(w_done_id), .done_tat(w_done_tat),
        .empty(w_empty), .full(w_full));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the main DUT in its first RUN cycle (timer 0).
    task automatic reset_start();
        in_valid = 1'b0; in_rt = '0; in_id = '0; start = 1'b0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        logic [24:0] rv;
        rv = {1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, task_out, done_valid, empty, full, done_id[0], done_tat[3:0]} !== rv) begin
            n_bad++; $display("FAIL reset_initial: got %h want %h",
                {in_ready, out_valid, task_out, done_valid, empty, full, done_id[0], done_tat[3:0]}, rv);
        end
        reset_start();
        in_valid = 1'b1; in_rt = 4'd2; in_id = 16'h5A5A;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || task_out !== 16'h5A5A) begin
            n_bad++; $display("FAIL reset_prerun: got %b/%h want 1/5a5a", out_valid, task_out);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, task_out, done_valid, done_id, done_tat, empty, full} !==
            {1'b0, 1'b0, 16'hFFFF, 1'b0, 16'h0, 6'h0, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL reset_midrun: got %b %b %h %b %h %h %b %b", in_ready, out_valid,
                task_out, done_valid, done_id, done_tat, empty, full);
        end
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1; in_rt = 4'd3; in_id = 16'h1234;
        for (int t = 0; t < 3; t++) begin
            n_cmp++;
            if (in_ready !== 1'b0 || out_valid !== 1'b0 || empty !== 1'b1) begin
                n_bad++; $display("FAIL idle_hold: cyc %0d ready %b ov %b empty %b want 0 0 1", t,
                    in_ready, out_valid, empty);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_sjf_order();
        logic [15:0] e_to [6];
        logic        e_dv [6];
        logic [5:0]  e_tat [6];
        logic        e_ov [6];
        logic        e_em [6];
        logic [41:0] got, exp_v;
`ifdef SJF_PREEMPT_EN
        e_to  = '{16'hFFFF, 16'h00AA, 16'h00BB, 16'h00AA, 16'h00AA, 16'hFFFF};
        e_dv  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        e_tat = '{6'd0, 6'd0, 6'd1, 6'd0, 6'd4, 6'd0};
`else
        e_to  = '{16'hFFFF, 16'h00AA, 16'h00AA, 16'h00AA, 16'h00BB, 16'hFFFF};
        e_dv  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        e_tat = '{6'd0, 6'd0, 6'd0, 6'd3, 6'd3, 6'd0};
`endif
        e_ov = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        e_em = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        reset_start();
        for (int t = 0; t < 6; t++) begin
            in_valid = (t < 2);
            in_rt    = (t == 0) ? 4'd3 : 4'd1;
            in_id    = (t == 0) ? 16'h00AA : 16'h00BB;
            got   = {in_ready, out_valid, task_out, done_valid, done_id, done_tat, empty};
            exp_v = {1'b1, e_ov[t], e_to[t], e_dv[t], (e_dv[t] ? e_to[t] : 16'h0), e_tat[t], e_em[t]};
            n_cmp++;
            if (got !== exp_v) begin
                n_bad++; $display("FAIL sjf_order t=%0d: got %h want %h", t, got, exp_v);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_full();
        reset_start();
        for (int t = 0; t < 18; t++) begin
            in_valid = (t < 17);
            in_rt    = (t < 5) ? 4'd15 : 4'd7;
            in_id    = (t < 5) ? 16'(16'h0100 + t) : 16'h01FF;
            n_cmp++;
            if (t < 5) begin
                if (in_ready !== 1'b1) begin
                    n_bad++; $display("FAIL full_fill t=%0d: in_ready %b want 1", t, in_ready);
                end
            end else if (t < 16) begin
                if ({in_ready, full, task_out} !== {1'b0, 1'b1, 16'h0100}) begin
                    n_bad++; $display("FAIL full_hold t=%0d: got %b %b %h want 0 1 0100", t,
                        in_ready, full, task_out);
                end
            end else if (t == 16) begin
                if ({in_ready, full, task_out} !== {1'b1, 1'b0, 16'h0101}) begin
                    n_bad++; $display("FAIL full_release: got %b %b %h want 1 0 0101", in_ready,
                        full, task_out);
                end
            end else begin
                if ({in_ready, full, task_out} !== {1'b0, 1'b1, 16'h0101}) begin
                    n_bad++; $display("FAIL full_refill: got %b %b %h want 0 1 0101", in_ready,
                        full, task_out);
                end
            end
            if (t == 15) begin
                n_cmp++;
                if ({done_valid, done_id, done_tat} !== {1'b1, 16'h0100, 6'd15}) begin
                    n_bad++; $display("FAIL full_done0: got %b %h %0d want 1 0100 15", done_valid,
                        done_id, done_tat);
                end
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Older task in a higher slot beats a newer equal-burst task reusing slot 0.
    task automatic test_tiebreak();
        logic [15:0] eid;
        logic        edv;
        logic [5:0]  etat;
        reset_start();
        for (int t = 0; t < 19; t++) begin
            in_valid = (t == 0 || t == 1 || t == 2 || t == 5);
            case (t)
                0: begin in_rt = 4'd4; in_id = 16'h1111; end
                1: begin in_rt = 4'd5; in_id = 16'h2222; end
                2: begin in_rt = 4'd3; in_id = 16'h3333; end
                default: begin in_rt = 4'd5; in_id = 16'h4444; end
            endcase
            if (t == 0 || t == 18)  eid = 16'hFFFF;
            else if (t <= 4)        eid = 16'h1111;
            else if (t <= 7)        eid = 16'h3333;
            else if (t <= 12)       eid = 16'h2222;
            else                    eid = 16'h4444;
            edv  = (t == 4 || t == 7 || t == 12 || t == 17);
            etat = (t == 4) ? 6'd4 : (t == 7) ? 6'd5 : (t == 12) ? 6'd11 : (t == 17) ? 6'd12 : 6'd0;
            n_cmp++;
            if ({out_valid, task_out, done_valid, done_id, done_tat} !==
                {(eid != 16'hFFFF), eid, edv, (edv ? eid : 16'h0), etat}) begin
                n_bad++; $display("FAIL tiebreak t=%0d: got %b %h %b %h %0d want id %h done %b tat %0d",
                    t, out_valid, task_out, done_valid, done_id, done_tat, eid, edv, etat);
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_zero_rt();
        reset_start();
        in_valid = 1'b1; in_rt = 4'd0; in_id = 16'hDEAD;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL zero_rt_ready: got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        for (int t = 1; t < 6; t++) begin
            n_cmp++;
            if ({empty, out_valid, done_valid, task_out} !== {1'b1, 1'b0, 1'b0, 16'hFFFF}) begin
                n_bad++; $display("FAIL zero_rt t=%0d: got %b %b %b %h want 1 0 0 ffff", t, empty,
                    out_valid, done_valid, task_out);
            end
            tick();
        end
    endtask

    task automatic test_wrap_reset();
        w_in_valid = 1'b0; w_rst_n = 1'b0;
        tick(); tick();
        w_rst_n = 1'b1;
        tick();
        w_start = 1'b1;
        tick();
        w_start = 1'b0;
        repeat (14) tick();
        w_in_valid = 1'b1; w_in_rt = 4'd3; w_in_id = 16'h7777;
        n_cmp++;
        if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0) begin
            n_bad++; $display("FAIL wrap_accept: ready %b ov %b want 1 0", w_in_ready, w_out_valid);
        end
        tick();
        w_in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if ({w_out_valid, w_task_out, w_done_valid, w_done_tat} !==
                {1'b1, 16'h7777, (k == 2), ((k == 2) ? 4'd3 : 4'd0)}) begin
                n_bad++; $display("FAIL wrap_run k=%0d: got %b %h %b %0d", k, w_out_valid,
                    w_task_out, w_done_valid, w_done_tat);
            end
            tick();
        end
        w_in_valid = 1'b1; w_in_rt = 4'd5; w_in_id = 16'h8888;
        tick();
        w_in_valid = 1'b0;
        tick();
        n_cmp++;
        if (w_out_valid !== 1'b1 || w_task_out !== 16'h8888) begin
            n_bad++; $display("FAIL wrap_second: got %b %h want 1 8888", w_out_valid, w_task_out);
        end
        #2 w_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({w_in_ready, w_out_valid, w_task_out, w_done_valid, w_done_id, w_done_tat, w_empty, w_full} !==
            {1'b0, 1'b0, 16'hFFFF, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0}) begin
            n_bad++; $display("FAIL wrap_async_reset: got %b %b %h %b %h %h %b %b", w_in_ready,
                w_out_valid, w_task_out, w_done_valid, w_done_id, w_done_tat, w_empty, w_full);
        end
        tick();
        w_rst_n = 1'b1;
    endtask

    // Reference: among occupied slots pick the minimum of one ordering key per slot.
    task automatic test_random();
        int          m_rem [SLOTS];
        int          m_arr [SLOTS];
        logic [15:0] m_id  [SLOTS];
        int          m_timer;
        bit          m_run_vld;
        int          m_run_idx;
        bit          lock_rule;
`ifdef SJF_PREEMPT_EN
        lock_rule = 1'b0;
`else
        lock_rule = 1'b1;
`endif
        reset_start();
        for (int i = 0; i < SLOTS; i++) begin m_rem[i] = 0; m_arr[i] = 0; m_id[i] = '0; end
        m_timer = 0; m_run_vld = 1'b0; m_run_idx = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            int e, fr, best_key, key, age;
            bit efull, eempty, edv;
            logic [15:0] eto;
            logic [5:0]  etat;
            logic [42:0] got, exp_v;
            in_valid = ($urandom_range(0, 99) < 45);
            in_rt    = ($urandom_range(0, 11) == 0) ? 4'd0
                     : 4'($urandom_range(1, ($urandom_range(0, 3) == 0) ? 15 : 5));
            in_id    = 16'($urandom);
            efull = 1'b1; eempty = 1'b1; fr = -1;
            for (int i = 0; i < SLOTS; i++) begin
                if (m_rem[i] != 0) eempty = 1'b0;
                else begin efull = 1'b0; if (fr < 0) fr = i; end
            end
            e = -1; best_key = 1 << 30;
            if (lock_rule && m_run_vld) e = m_run_idx;
            else begin
                for (int i = 0; i < SLOTS; i++) begin
                    if (m_rem[i] != 0) begin
                        age = (m_timer - m_arr[i] + 64) % 64;
                        key = m_rem[i] * 4096 + ((m_run_vld && m_run_idx == i) ? 0 : 2048)
                            + (63 - age) * 16 + i;
                        if (key < best_key) begin best_key = key; e = i; end
                    end
                end
            end
            edv  = (e >= 0) && (m_rem[e] == 1);
            eto  = (e >= 0) ? m_id[e] : 16'hFFFF;
            etat = edv ? 6'((m_timer - m_arr[e] + 64) % 64) : 6'd0;
            got   = {in_ready, out_valid, task_out, done_valid, done_id, done_tat, empty, full};
            exp_v = {!efull, (e >= 0), eto, edv, (edv ? eto : 16'h0), etat, eempty, efull};
            n_cmp++;
            if (got !== exp_v) begin
                n_bad++; $display("FAIL random cyc=%0d: got %h want %h", cyc, got, exp_v);
            end
            if (e >= 0) begin
                m_rem[e]--;
                if (m_rem[e] == 0) m_run_vld = 1'b0;
                else begin m_run_vld = 1'b1; m_run_idx = e; end
            end
            if (in_valid && !efull && in_rt != 4'd0) begin
                m_rem[fr] = int'(in_rt); m_arr[fr] = m_timer; m_id[fr] = in_id;
            end
            m_timer = (m_timer + 1) % 64;
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sjf_order();
        test_full();
        test_tiebreak();
        test_zero_rt();
        test_wrap_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sjf_sched_param.md
Name: sjf_sched_param

Overview:
- Parametrised shortest-job-first task scheduler with N task slots and configurable remaining-time, ID and timestamp widths.
- Accepts tasks over a valid/ready handshake and executes one time unit per cycle.
- Ties break by age, then by lowest slot index.
- Reports a per-task completion pulse with turnaround time. Sits between the task source and the execution-unit model, as the next generation of the fixed 5-slot SJF scheduler.

Parameters:
- SLOTS, 5, number of task slots (2..16).
- RT_W, 4, remaining/burst-time width; burst 0 is invalid.
- ID_W, 16, task ID/payload width.
- TIME_W, 6, free-running timestamp width; wraps.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  leaves IDLE when high in IDLE.
- in_valid  in  1  task offered.
- in_ready  out  1  slot available and state RUN.
- in_rt  in  RT_W  burst time of the offered task.
- in_id  in  ID_W  task ID.
- out_valid  out  1  a task executes this cycle.
- task_out  out  ID_W  executing task ID; all-ones when out_valid=0.
- done_valid  out  1  executing task finishes this cycle.
- done_id  out  ID_W  ID of the finishing task.
- done_tat  out  TIME_W  turnaround = timer - arrival (mod 2^TIME_W).
- empty  out  1  no slot occupied.
- full  out  1  all slots occupied.

Behaviour:
- Reset (async, any state, including mid-execution):
  - state=IDLE, timer=0, lock invalid, all slot rem=0.
  - Outputs: in_ready=0, out_valid=0, task_out=all-ones, done_valid=0, done_id=0, done_tat=0, empty=1, full=0.
- States:
  - IDLE -> RUN when start=1. RUN never returns to IDLE except via reset.
- Slot storage and occupancy:
  - Each slot holds {arrival[TIME_W], rem[RT_W], id[ID_W]}.
  - A slot is occupied iff rem!=0.
- Timer: increments by 1 every RUN cycle and wraps. Frozen at 0 in IDLE.
- Accept:
  - in_ready = (state==RUN) && !full, computed from current registers only.
  - On in_valid&&in_ready, write the lowest-index free slot with arrival=current timer, rem=in_rt, id=in_id.
  - An accepted task is eligible for selection from the next cycle, never in its acceptance cycle.
  - in_rt==0: the handshake completes (in_ready honoured), but no slot is written and no completion is ever reported.
- Selection (combinational, RUN only):
  - Candidates are occupied slots.
  - Order: minimum rem; then oldest, i.e. largest (timer - arrival) mod 2^TIME_W; then lowest index.
  - Non-preemptive: if lock is valid, the locked slot executes regardless of other candidates. Otherwise the selection winner executes and lock is set to it.
- Execute:
  - out_valid=1 and task_out=slot id; rem decrements by 1 at the edge.
  - When rem==1 in the executing cycle: done_valid=1, done_id=id, done_tat=timer-arrival. At the edge the slot frees and lock clears.
  - A freed slot is visible to in_ready in the next cycle.
- Idle RUN cycle: no occupied slot -> out_valid=0, task_out=all-ones, timer still advances.
- Simultaneous accept and execute in one cycle is allowed; they touch different slots by construction.
- Outputs are combinational from registered state. Latency from acceptance to first execution is ≥1 cycle.
- Widths: the timer subtraction is modulo 2^TIME_W. Ages wider than 2^TIME_W-1 alias, which is acceptable and documented.

Optional Feature:
- Macro SJF_PREEMPT_EN.
- Defined: shortest-remaining-time-first. Selection is re-evaluated every RUN cycle and the lock is ignored. A new shorter task preempts the running task from its first eligible cycle. On an exact rem tie, the currently running slot wins over age/index, to avoid thrashing.
- Undefined: non-preemptive locking as above.

Test Plan:
1. SLOTS=5, non-preemptive. start, then A(id 0x00AA, rt 3) accepted at timer 0, B(0x00BB, rt 1) at timer 1 -> task_out AA,AA,AA,BB at timers 1..4. Done A at timer 3 with tat 3; done B at timer 4 with tat 3; empty=1 at timer 5.
2. Same stimulus with SJF_PREEMPT_EN -> task_out AA,BB,AA,AA at timers 1..4. Done B at timer 2 with tat 1; done A at timer 4 with tat 4.
3. Fill 5 slots with rt 15 at timers 0..4, hold a 6th in_valid -> in_ready=0, full=1 until the cycle after slot 0 completes (timer 16). The 6th task is accepted into slot 0 at timer 16.
4. Tie-break with slot reuse: slot 0 freed, then C(rt 5, arrival 20) in slot 1 and D(rt 5, arrival 22) in slot 0 -> C executes first despite the higher index.
5. in_rt=0 offered while empty -> handshake accepted, empty stays 1, out_valid=0, no done_valid ever.
6. TIME_W=4, task rt 3 accepted at timer 14 -> runs at timers 15, 0, 1. done_tat=3 at timer 1. Then assert rst_n=0 mid-run -> all outputs at reset values immediately.
